// File: rtl/uart_pkg.sv
// Purpose: shared UART constants (Tx FSM state encoding, ParityType codes, idle line level).
// Latency: n/a, constants and one pure helper function.
// Backpressure: n/a.
// Ports: none (package).
package uart_pkg;

  // Tx frame FSM states. ST_PARITY is only reachable when UART_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_t;

  // ParityType codes; 2'b11 also means "no parity".
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Idle (mark) level of the serial line.
  localparam logic LINE_IDLE = 1'b1;

  // Parity bit for up to 8 data bits. Narrower data is zero-extended by the
  // caller, which leaves the XOR unchanged.
  function automatic logic parity_of(input logic [7:0] data, input logic [1:0] ptype);
    return (^data) ^ (ptype == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Purpose: handshake/data bundle between the Tx requester, BaudRateGen and uart_tx_frame.
// Latency: n/a, wires only.
// Backpressure: Busy=1 means Send is ignored; there is no request queue.
// Ports (signals): BaudOut, Send, DataIn[DATA_W], ParityType[2], StopBits (toward framer);
//                  TxD, Busy, Done (from framer).
interface uart_tx_frame_if #(
  parameter int DATA_W = 8
);
  logic              BaudOut;
  logic              Send;
  logic [DATA_W-1:0] DataIn;
  logic [1:0]        ParityType;
  logic              StopBits;
  logic              TxD;
  logic              Busy;
  logic              Done;

  // Requester / baud source side.
  modport master (
    output BaudOut, Send, DataIn, ParityType, StopBits,
    input  TxD, Busy, Done
  );

  // Framer side.
  modport slave (
    input  BaudOut, Send, DataIn, ParityType, StopBits,
    output TxD, Busy, Done
  );
endinterface

// File: rtl/uart_tick_det.sv
// Purpose: rising-edge detector turning the sampled BaudOut level into a one-clock tick.
// Latency: tick is combinational in the cycle BaudOut is first seen high after a low sample.
// Backpressure: none; ticks are never held or queued.
// Ports: Clock, ResetN (async, active-low), i_baud (baud level), o_tick (one-cycle pulse).
module uart_tick_det (
  input  logic Clock,
  input  logic ResetN,
  input  logic i_baud,
  output logic o_tick
);

  logic r_bo_q;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_bo_q <= 1'b0;
    end else begin
      r_bo_q <= i_baud;
    end
  end

  // Clearing r_bo_q on reset means a BaudOut already high at release counts as a tick.
  assign o_tick = i_baud & ~r_bo_q;

endmodule

// File: rtl/uart_tx_frame.sv
// Purpose: serialise one DATA_W-bit word into a UART frame (start, data LSB first, [parity], 1-2 stop).
// Latency: Busy rises 1 clock after acceptance; TxD falls on the first BaudOut tick after acceptance.
// Backpressure: Send is only taken while Busy=0; requests during a frame are dropped.
// Ports: Clock, ResetN (async, active-low), bus (uart_tx_frame_if.slave: BaudOut, Send, DataIn,
//        ParityType, StopBits in; TxD, Busy, Done out). All outputs are registered.
// Build option: define UART_TX_PARITY_EN to compile in the parity bit; otherwise ParityType is ignored.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic           Clock,
  input  logic           ResetN,
  uart_tx_frame_if.slave bus
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_stop2;
  logic              r_stop_cnt;
  logic              r_txd;
  logic              r_busy;
  logic              r_done;

`ifdef UART_TX_PARITY_EN
  logic [1:0]        r_par_type;
  logic              r_par_bit;
  logic              w_par_on;
`else
  logic              w_unused_par;
`endif

  logic              w_tick;
  logic              w_accept;
  logic              w_load;
  logic              w_shift;
  logic              w_stop_clr;
  logic              w_stop_adv;
  logic              w_txd_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  uart_tick_det u_tick_det (
    .Clock  (Clock),
    .ResetN (ResetN),
    .i_baud (bus.BaudOut),
    .o_tick (w_tick)
  );

`ifdef UART_TX_PARITY_EN
  assign w_par_on = (r_par_type == PAR_ODD) || (r_par_type == PAR_EVEN);
`else
  assign w_unused_par = ^bus.ParityType;
`endif

  // Next-state and next-output logic. TxD is registered, so each branch sets
  // the level the line takes from the tick edge that leaves the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_txd_nxt   = r_txd;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_stop_clr  = 1'b0;
    w_stop_adv  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_txd_nxt = LINE_IDLE;
        // A tick coinciding with acceptance is deliberately not used: WAIT
        // only reacts to ticks seen after it is entered.
        if (bus.Send && !r_busy) begin
          w_accept    = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (w_tick) begin
          w_state_nxt = ST_START;
          w_txd_nxt   = 1'b0;
        end
      end

      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_load      = 1'b1;
          w_txd_nxt   = r_data[0];
        end
      end

      ST_DATA: begin
        // r_cnt counts data bits already put on the line (1..DATA_W).
        if (w_tick) begin
          if (r_cnt == CNT_LAST) begin
`ifdef UART_TX_PARITY_EN
            if (w_par_on) begin
              w_state_nxt = ST_PARITY;
              w_txd_nxt   = r_par_bit;
            end else begin
              w_state_nxt = ST_STOP;
              w_txd_nxt   = LINE_IDLE;
              w_stop_clr  = 1'b1;
            end
`else
            w_state_nxt = ST_STOP;
            w_txd_nxt   = LINE_IDLE;
            w_stop_clr  = 1'b1;
`endif
          end else begin
            w_shift   = 1'b1;
            w_txd_nxt = r_shift[0];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt = ST_STOP;
          w_txd_nxt   = LINE_IDLE;
          w_stop_clr  = 1'b1;
        end
      end
`endif

      ST_STOP: begin
        if (w_tick) begin
          if (r_stop2 && !r_stop_cnt) begin
            w_stop_adv = 1'b1;
          end else begin
            // Busy drops and Done pulses together, so a held Send is taken
            // on the very next edge.
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_txd_nxt   = LINE_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= ST_IDLE;
      r_txd   <= LINE_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Request latch, shift register and counters.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_data     <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_type <= PAR_NONE;
      r_par_bit  <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_data     <= bus.DataIn;
        r_stop2    <= bus.StopBits;
`ifdef UART_TX_PARITY_EN
        r_par_type <= bus.ParityType;
        r_par_bit  <= parity_of(8'(bus.DataIn), bus.ParityType);
`endif
      end

      // Bit 0 goes straight to TxD on load, so the shifter keeps the rest.
      if (w_load) begin
        r_shift <= r_data >> 1;
        r_cnt   <= CNT_W'(1);
      end else if (w_shift) begin
        r_shift <= r_shift >> 1;
        r_cnt   <= r_cnt + 1'b1;
      end

      if (w_stop_clr) begin
        r_stop_cnt <= 1'b0;
      end else if (w_stop_adv) begin
        r_stop_cnt <= 1'b1;
      end
    end
  end

  assign bus.TxD  = r_txd;
  assign bus.Busy = r_busy;
  assign bus.Done = r_done;

endmodule
